// File: rtl/token_ratio_divider_if.sv
// token_ratio_divider_if: token lanes, enable and config handshake of the token ratio divider
interface token_ratio_divider_if #(parameter int CHANNELS = 4, parameter int CNT_W = 4);
    logic                en;
    logic [CHANNELS-1:0] a;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CNT_W-1:0]    cfg_div;
    logic [CNT_W-1:0]    cfg_phase;
    logic [CHANNELS-1:0] b;
    logic [CHANNELS-1:0] pending;
    modport master (output en, a, cfg_valid, cfg_div, cfg_phase, input cfg_ready, b, pending);
    modport slave  (input en, a, cfg_valid, cfg_div, cfg_phase, output cfg_ready, b, pending);
endinterface

// File: rtl/token_ratio_divider.sv
// token_ratio_divider: per-channel 1-of-DIV token pass filter with runtime divisor/phase config
module token_ratio_divider #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4
) (
    input logic clk,
    input logic rst,
    token_ratio_divider_if.slave io
);
    typedef enum logic {IDLE, APPLY} state_t;
    state_t              state;
    logic                ready_r;
    logic [CNT_W-1:0]    div_r, phase_r, div_s, phase_s;
    logic [CNT_W-1:0]    cnt    [CHANNELS];
    logic [CNT_W-1:0]    cnt_nx [CHANNELS];
    logic [CHANNELS-1:0] b_r, b_nx, pend;
    // sanitising keeps phase_r < div_r so every group has exactly one pass slot
    always_comb begin
        div_s   = io.cfg_div == '0 ? CNT_W'(1) : io.cfg_div;
        phase_s = io.cfg_phase >= div_s ? div_s - CNT_W'(1) : io.cfg_phase;
        b_nx    = '0;
        pend    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nx[i] = state == APPLY ? '0 :
                        !(io.en && io.a[i]) ? cnt[i] :
                        cnt[i] == div_r - CNT_W'(1) ? '0 : cnt[i] + CNT_W'(1);
            b_nx[i]   = state == IDLE && io.en && io.a[i] && cnt[i] == phase_r;
            pend[i]   = cnt[i] != '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready_r <= 1'b1;
            div_r   <= CNT_W'(2);
            phase_r <= CNT_W'(1);
            b_r     <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
            b_r <= b_nx;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_nx[i];
            if (state == APPLY) begin
                state   <= IDLE;
                ready_r <= 1'b1;
            end else if (io.cfg_valid) begin
                state   <= APPLY;
                ready_r <= 1'b0;
                div_r   <= div_s;
                phase_r <= phase_s;
            end
        end
    end
    assign io.b         = b_r;
    assign io.pending   = pend;
    assign io.cfg_ready = ready_r;
endmodule

// File: tb/tb_token_ratio_divider.sv
// tb_token_ratio_divider: directed stimulus with a behavioural model feeding a scoreboard queue
module tb_token_ratio_divider;
    typedef struct {logic [3:0] b; logic [3:0] pend; logic rdy;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    token_ratio_divider_if #(.CHANNELS(4), .CNT_W(4)) io ();
    token_ratio_divider #(.CHANNELS(4), .CNT_W(4)) dut (.clk(clk), .rst(rst), .io(io.slave));
    always #5 clk = ~clk;

    exp_t       sbq[$];
    int         n_cmp = 0, n_fail = 0;
    logic [15:0] cap0, cap1;
    logic [3:0] m_b, m_pend;
    bit         m_apply;
    int         m_div, m_phase;
    int         m_cnt [4];
    logic [15:0] pat [4] = '{16'hA5C3, 16'h0F0F, 16'hFFFF, 16'h3B61};

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_step(input logic r, input logic e, input logic [3:0] av, input logic cv, input int cd, input int cp);
        int d, p;
        if (r) begin
            m_apply = 0; m_div = 2; m_phase = 1; m_b = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_b[i] = 1'b0;
                if (m_apply) m_cnt[i] = 0;
                else if (e && av[i]) begin
                    m_b[i] = (m_cnt[i] == m_phase);
                    m_cnt[i] = (m_cnt[i] + 1) % m_div;
                end
            end
            if (m_apply) m_apply = 0;
            else if (cv) begin
                d = (cd == 0) ? 1 : cd;
                p = (cp >= d) ? d - 1 : cp;
                m_div = d; m_phase = p; m_apply = 1;
            end
        end
        for (int i = 0; i < 4; i++) m_pend[i] = (m_cnt[i] != 0);
    endtask

    task automatic cyc(input logic r, input logic e, input logic [3:0] av, input logic cv, input logic [3:0] cd, input logic [3:0] cp);
        exp_t x;
        @(negedge clk);
        rst = r; io.en = e; io.a = av; io.cfg_valid = cv; io.cfg_div = cd; io.cfg_phase = cp;
        m_step(r, e, av, cv, int'(cd), int'(cp));
        x.b = m_b; x.pend = m_pend; x.rdy = !m_apply;
        sbq.push_back(x);
    endtask

    task automatic tok(input logic [3:0] av);
        cyc(1'b0, 1'b1, av, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic cfg(input logic [3:0] d, input logic [3:0] p);
        cyc(1'b0, 1'b1, 4'b0000, 1'b1, d, p);
        cyc(1'b0, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("b", int'(io.b), int'(e.b));
                chk("pending", int'(io.pending), int'(e.pend));
                chk("cfg_ready", int'(io.cfg_ready), int'(e.rdy));
                cap0 = {cap0[14:0], io.b[0]};
                cap1 = {cap1[14:0], io.b[1]};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] s;
        logic [3:0]  av;
        io.en = 1'b0; io.a = '0; io.cfg_valid = 1'b0; io.cfg_div = '0; io.cfg_phase = '0;
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0);
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0);
        // reset config halves channel 0
        s = 16'b1100111010001111;
        @(negedge clk); cap0 = '0;
        for (int k = 0; k < 16; k++) tok({3'b000, s[15-k]});
        drain();
        chk("halving_seq", int'(cap0), int'(16'b0100010010000101));
        // DIV=3 PHASE=0 on channel 1
        cfg(4'd3, 4'd0);
        @(negedge clk); cap1 = '0;
        for (int k = 0; k < 7; k++) tok(4'b0010);
        drain();
        chk("div3_seq", int'(cap1[6:0]), int'(7'b1001001));
        chk("div3_pending", int'(io.pending[1]), 1);
        // div 0 sanitised to 1: every token passes
        cfg(4'd0, 4'd5);
        for (int k = 0; k < 6; k++) tok(4'b1111);
        tok(4'b0101);
        // phase clamp and APPLY clearing partial groups
        cfg(4'd4, 4'd9);
        tok(4'b1100);
        tok(4'b1100);
        cyc(1'b0, 1'b1, 4'b1111, 1'b1, 4'd4, 4'd3);
        cyc(1'b0, 1'b1, 4'b1111, 1'b1, 4'd4, 4'd3);
        cyc(1'b0, 1'b1, 4'b1111, 1'b0, 4'd0, 4'd0);
        for (int k = 0; k < 3; k++) tok(4'b0100);
        // enable low holds counters
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 4'b1111, 1'b0, 4'd0, 4'd0);
        cyc(1'b0, 1'b0, 4'b1111, 1'b1, 4'd4, 4'd2);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0);
        for (int k = 0; k < 5; k++) tok(4'b1111);
        // independent channels with a reset pulse and a discarded config
        cfg(4'd5, 4'd2);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) av[i] = pat[i][15-k];
            cyc(k == 8, 1'b1, av, k == 8, 4'd7, 4'd1);
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
